axin_pktcheck: RTL
==================

# axin_pktcheck

Synthesizable AXIN packet sink/checker that sits directly downstream of the bench packet generator (and of any AXIN source in the switch). It accepts 32-bit AXIN beats and validates each frame's Ethernet FCS with a 1–4-byte-per-beat CRC32 engine. Per packet it reports length and status, and it keeps running counters of good, bad, runt, giant and aborted frames. Typical use is as a bench scoreboard and as an in-fabric monitor.

## Interface
- MIN_LENGTH, 64: frames shorter than this many bytes (FCS included) are runts.
- MAX_LENGTH, 1518: frames longer than this many bytes (FCS included) are giants.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_VALID  in  1  beat valid.
- S_READY  out  1  beat accepted when S_VALID && S_READY.
- S_DATA  in  32  first byte of the beat in [7:0], then [15:8], and so on.
- S_BYTES  in  2  valid bytes on a LAST beat; 0 means 4. Ignored when S_LAST is low.
- S_LAST  in  1  final beat of the packet.
- S_ABORT  in  1  abandon the current packet.
- i_clear  in  1  synchronous clear of all counters.
- o_done  out  1  one-cycle pulse: a packet finished (not aborted).
- o_done_len  out  16  byte count of that packet, including FCS; saturates at 0xFFFF.
- o_done_status  out  3  {giant, runt, crc_err} for that packet.
- o_good_count, o_crcerr_count, o_runt_count, o_giant_count, o_abort_count  out  32 each  event counters.

## Operation
- FSM has two states: IDLE (between packets) and BUSY (at least one beat accepted, no LAST or abort yet).
- S_READY is 0 while reset is asserted and 1 on every other cycle. The block never back-pressures.
- Beat byte count n is 4 on non-LAST beats and {S_BYTES==0 ? 4 : S_BYTES} on LAST beats. Bytes above n are ignored.
- CRC: reflected polynomial 0xEDB88320, register initialized to 0xFFFFFFFF at the first beat of each packet, bytes processed LSB-first. The FCS is fed through the engine like any other byte.
- The frame is good when the final register equals the residue 0xDEBB20E3. crc_err = (final != 0xDEBB20E3).
- Length accumulator: reset to n on the first beat, then len += n on each beat. It saturates at 0xFFFF.
- On an accepted LAST beat:
  - runt = len < MIN_LENGTH; giant = len > MAX_LENGTH.
  - Exactly one counter increments: crcerr if crc_err; else giant; else runt; else good.
  - State returns to IDLE.
- A single-beat packet (LAST on the first beat) is legal and goes IDLE→IDLE.
- Abort occurs when S_ABORT && (state==BUSY || S_VALID):
  - abort_count increments.
  - Any beat accepted that cycle is discarded, even if LAST.
  - state→IDLE; no o_done.
- S_ABORT in IDLE with S_VALID low is ignored.
- Abort and LAST in the same cycle: abort wins.
- i_clear zeros all five counters. When i_clear coincides with an increment, clear wins and the increment is lost. i_clear does not affect packet state.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - S_READY=0, o_done=0, o_done_len=0, o_done_status=0.
  - All counters 0; state IDLE; CRC register 0xFFFFFFFF; length 0.
- Latency: the LAST beat is accepted at edge k. o_done, o_done_len, o_done_status and the incremented counter are all valid from edge k+1; o_done is high for exactly one cycle.
- o_done_len and o_done_status hold their values until the next o_done.
- A new packet's first beat may be accepted in the cycle directly after a LAST beat. Back-to-back packets run at full rate.
- Reset mid-packet discards the partial packet: no counter change and no o_done.
- The CRC step for up to 4 bytes is combinational within one cycle. No pipelining is needed at the 32-bit width.

## Structure
- Package axin_pkg holds:
  - CRC_POLY = 32'hEDB88320, CRC_INIT = 32'hFFFFFFFF, CRC_RESIDUE = 32'hDEBB20E3.
  - The state enum {IDLE, BUSY}.
  - Status bit indices CRC_ERR=0, RUNT=1, GIANT=2.
- One sub-module, axin_crc32_step: a combinational next-CRC calculation from (crc_in[31:0], data[31:0], nbytes[2:0]) to crc_out[31:0], with nbytes in the range 1..4, built as 4 chained byte stages.
- The top level holds the FSM, length accumulator, CRC register, counters and output registers.

## Test plan
- Bytes "123456789" followed by 26 39 F4 CB sent as 4 beats, last beat with S_BYTES=1 (13 bytes) → o_done_len=13, status=3'b010 (runt only), runt_count=1.
- 60-byte frame plus its correct FCS (64 bytes, 16 beats, S_BYTES=0) → status=0, good_count=1, o_done exactly one cycle after the LAST beat.
- Same frame with bit 0 of byte 10 flipped → status bit0=1, crcerr_count=1, good_count unchanged.
- Abort asserted on the 5th beat of a 64-byte frame, then a clean 64-byte frame → abort_count=1, good_count=1, only one o_done.
- 1519-byte frame with correct FCS (last beat S_BYTES=3) → len=1519, status=3'b100, giant_count=1.
- Back-to-back good frames with i_clear asserted in the o_done cycle of the first → all counters 0 after the clear, good_count=1 after the second frame. Also drop reset mid-packet → no o_done, counters 0.

Source files
------------

// File: rtl/axin_pkg.sv
// Shared constants, state encoding and the bytewise CRC32 helper for the
// AXIN packet checker.
package axin_pkg;

    // Reflected Ethernet CRC32 polynomial, seed and good-frame residue
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Packet FSM: IDLE between packets, BUSY once a non-final beat is taken
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bit positions inside o_done_status
    localparam int CRC_ERR = 0;
    localparam int RUNT    = 1;
    localparam int GIANT   = 2;

    // One byte through the reflected CRC, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/axin_crc32_step.sv
// Combinational CRC32 update for one AXIN beat carrying 1..4 bytes.
// Byte 0 sits in data[7:0]; bytes at index >= nbytes pass the CRC unchanged.
module axin_crc32_step
    import axin_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] crc_out
);

    logic [31:0] stage [0:4];

    assign stage[0] = crc_in;

    // Four chained byte stages, each either folds its byte in or bypasses
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign stage[i+1] = (3'(i) < nbytes) ? crc32_byte(stage[i], data[8*i +: 8])
                                             : stage[i];
    end

    assign crc_out = stage[4];

endmodule

// File: rtl/axin_pktcheck.sv
// AXIN packet sink: checks each frame's FCS, measures its length, reports a
// per-packet done pulse with status and keeps running event counters.
//
// Handshake: a beat transfers on a rising edge where S_VALID && S_READY.
// S_READY is simply "not in reset", so the sink never back-pressures;
// S_ABORT is honoured whenever a packet is open or a beat is offered.
module axin_pktcheck
    import axin_pkg::*;
#(
    parameter int MIN_LENGTH = 64,
    parameter int MAX_LENGTH = 1518
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [31:0] S_DATA,
    input  logic [1:0]  S_BYTES,
    input  logic        S_LAST,
    input  logic        S_ABORT,
    input  logic        i_clear,
    output logic        o_done,
    output logic [15:0] o_done_len,
    output logic [2:0]  o_done_status,
    output logic [31:0] o_good_count,
    output logic [31:0] o_crcerr_count,
    output logic [31:0] o_runt_count,
    output logic [31:0] o_giant_count,
    output logic [31:0] o_abort_count,
    output state_t      dbg_state
);

    state_t      state_q;
    logic [31:0] crc_q;
    logic [15:0] len_q;

    logic        accept;
    logic        abort_evt;
    logic        finish_evt;
    logic        first_beat;
    logic [2:0]  beat_bytes;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [15:0] len_base;
    logic [16:0] len_sum;
    logic [15:0] len_next;
    logic [2:0]  status_next;
    logic        inc_good;
    logic        inc_crcerr;
    logic        inc_runt;
    logic        inc_giant;

    assign S_READY    = S_AXI_ARESETN;
    assign accept     = S_VALID && S_READY;
    assign abort_evt  = S_ABORT && ((state_q == BUSY) || S_VALID);
    assign finish_evt = accept && S_LAST && !abort_evt;
    assign first_beat = (state_q == IDLE);
    assign dbg_state  = state_q;

    // Bytes carried by this beat: full width unless it is the final beat
    always_comb begin
        beat_bytes = 3'd4;
        if (S_LAST && (S_BYTES != 2'd0)) begin
            beat_bytes = {1'b0, S_BYTES};
        end
    end

    // A new packet restarts from the seed and zero length
    assign crc_base = first_beat ? CRC_INIT : crc_q;
    assign len_base = first_beat ? 16'd0 : len_q;

    axin_crc32_step u_crc_step (
        .crc_in  (crc_base),
        .data    (S_DATA),
        .nbytes  (beat_bytes),
        .crc_out (crc_next)
    );

    // Saturating length update including this beat
    assign len_sum  = {1'b0, len_base} + {14'd0, beat_bytes};
    assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    // Classification of the packet that would complete on this beat
    always_comb begin
        status_next          = 3'b000;
        status_next[CRC_ERR] = (crc_next != CRC_RESIDUE);
        status_next[RUNT]    = (len_next < 16'(MIN_LENGTH));
        status_next[GIANT]   = (len_next > 16'(MAX_LENGTH));
    end

    // Exactly one counter moves per finished packet, CRC error first
    assign inc_crcerr = finish_evt && status_next[CRC_ERR];
    assign inc_giant  = finish_evt && !status_next[CRC_ERR] && status_next[GIANT];
    assign inc_runt   = finish_evt && !status_next[CRC_ERR] && !status_next[GIANT]
                        && status_next[RUNT];
    assign inc_good   = finish_evt && (status_next == 3'b000);

    // Packet FSM with CRC/length accumulation and registered done outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q       <= IDLE;
            crc_q         <= CRC_INIT;
            len_q         <= 16'd0;
            o_done        <= 1'b0;
            o_done_len    <= 16'd0;
            o_done_status <= 3'b000;
        end else begin
            o_done <= 1'b0;
            if (abort_evt) begin
                state_q <= IDLE;
                crc_q   <= CRC_INIT;
                len_q   <= 16'd0;
            end else if (accept) begin
                if (S_LAST) begin
                    state_q       <= IDLE;
                    crc_q         <= CRC_INIT;
                    len_q         <= 16'd0;
                    o_done        <= 1'b1;
                    o_done_len    <= len_next;
                    o_done_status <= status_next;
                end else begin
                    state_q <= BUSY;
                    crc_q   <= crc_next;
                    len_q   <= len_next;
                end
            end
        end
    end

    // Event counters; a clear in the same cycle as an increment wins
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || i_clear) begin
            o_good_count   <= 32'd0;
            o_crcerr_count <= 32'd0;
            o_runt_count   <= 32'd0;
            o_giant_count  <= 32'd0;
            o_abort_count  <= 32'd0;
        end else begin
            if (inc_good)   o_good_count   <= o_good_count + 32'd1;
            if (inc_crcerr) o_crcerr_count <= o_crcerr_count + 32'd1;
            if (inc_runt)   o_runt_count   <= o_runt_count + 32'd1;
            if (inc_giant)  o_giant_count  <= o_giant_count + 32'd1;
            if (abort_evt)  o_abort_count  <= o_abort_count + 32'd1;
        end
    end

endmodule
